// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised register file with two combinational read ports,
// one synchronous write port, optional write-to-read bypass and a per-register busy scoreboard.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rc,
    input  logic [DATA_W-1:0] dc,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NREG = 2**ADDR_W;
    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wr_ok;
    logic              iss_ok;
    logic              wr_clr;
    logic              cnt_inc;
    logic              cnt_dec;
    assign wr_ok  = RegWrite && !(ZERO_REG != 0 && rc == '0);
    assign iss_ok = issue && !(ZERO_REG != 0 && issue_reg == '0);
    // a same-cycle issue to the written register keeps it busy
    assign wr_clr  = wr_ok && !(iss_ok && issue_reg == rc);
    assign cnt_inc = iss_ok && !busy[issue_reg];
    assign cnt_dec = wr_clr && busy[rc];
    always_comb begin
        busy_nxt = busy;
        if (wr_clr)
            busy_nxt[rc] = 1'b0;
        if (iss_ok)
            busy_nxt[issue_reg] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok)
                mem[rc] <= dc;
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] idx);
        if (ZERO_REG != 0 && idx == '0)
            return '0;
        if (BYPASS != 0 && wr_ok && rc == idx)
            return dc;
        return mem[idx];
    endfunction
    assign da     = rd(ra);
    assign db     = rd(rb);
    assign busy_a = busy[ra] && !(BYPASS != 0 && wr_clr && rc == ra);
    assign busy_b = busy[rb] && !(BYPASS != 0 && wr_clr && rc == rb);
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed checks of reads, bypass, reset clear and busy scoreboard.
module tb_rf_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] da;
    logic [31:0] db;
    logic        issue;
    logic [4:0]  issue_reg;
    logic        busy_a;
    logic        busy_b;
    logic [5:0]  busy_cnt;
    int n_cmp = 0;
    int n_err = 0;

    rf_scoreboard dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rc(rc), .dc(dc),
        .ra(ra), .rb(rb), .da(da), .db(db), .issue(issue), .issue_reg(issue_reg),
        .busy_a(busy_a), .busy_b(busy_b), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; rc = '0; dc = '0; ra = '0; rb = '0; issue = 1'b0; issue_reg = '0;
        #3;
        chk("reset_da", da, 32'h0);
        chk("reset_cnt", 32'(busy_cnt), 32'd0);
        step();
        rst = 1'b0;
        // write r5 and issue r6 on the same edge, then reset between edges
        RegWrite = 1'b1; rc = 5'd5; dc = 32'hDEADBEEF; issue = 1'b1; issue_reg = 5'd6;
        step();
        RegWrite = 1'b0; issue = 1'b0; ra = 5'd5; rb = 5'd6;
        #1;
        chk("pre_rst_da", da, 32'hDEADBEEF);
        chk("pre_rst_busy_b", 32'(busy_b), 32'd1);
        chk("pre_rst_cnt", 32'(busy_cnt), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_da", da, 32'h0);
        chk("async_rst_busy_b", 32'(busy_b), 32'd0);
        chk("async_rst_cnt", 32'(busy_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_da", da, 32'h0);
        // zero register
        RegWrite = 1'b1; rc = 5'd0; dc = 32'h1234; issue = 1'b1; issue_reg = 5'd0; ra = 5'd0;
        #1;
        chk("zero_bypass_da", da, 32'h0);
        step();
        RegWrite = 1'b0; issue = 1'b0;
        #1;
        chk("zero_da", da, 32'h0);
        chk("zero_busy_a", 32'(busy_a), 32'd0);
        chk("zero_cnt", 32'(busy_cnt), 32'd0);
        // bypass
        RegWrite = 1'b1; rc = 5'd7; dc = 32'h55AA; ra = 5'd7; rb = 5'd7;
        #1;
        chk("byp_da", da, 32'h55AA);
        chk("byp_db", db, 32'h55AA);
        rb = 5'd8;
        #1;
        chk("byp_other_db", db, 32'h0);
        rb = 5'd7;
        step();
        RegWrite = 1'b0;
        #1;
        chk("byp_stored_da", da, 32'h55AA);
        chk("byp_stored_db", db, 32'h55AA);
        chk("write_nonbusy_cnt", 32'(busy_cnt), 32'd0);
        // scoreboard lifecycle on r3
        issue = 1'b1; issue_reg = 5'd3; ra = 5'd3;
        #1;
        chk("issue_same_cycle_busy_a", 32'(busy_a), 32'd0);
        step();
        issue = 1'b0;
        #1;
        chk("issue_busy_a", 32'(busy_a), 32'd1);
        chk("issue_cnt", 32'(busy_cnt), 32'd1);
        RegWrite = 1'b1; rc = 5'd3; dc = 32'd9;
        #1;
        chk("wb_busy_a_comb", 32'(busy_a), 32'd0);
        chk("wb_da_comb", da, 32'd9);
        chk("wb_cnt_before_edge", 32'(busy_cnt), 32'd1);
        step();
        RegWrite = 1'b0;
        #1;
        chk("wb_cnt", 32'(busy_cnt), 32'd0);
        chk("wb_busy_a", 32'(busy_a), 32'd0);
        chk("wb_da", da, 32'd9);
        // simultaneous issue and write: r2 busy first, then r4 both on one edge
        issue = 1'b1; issue_reg = 5'd2;
        step();
        issue_reg = 5'd4; RegWrite = 1'b1; rc = 5'd4; dc = 32'd1; ra = 5'd4;
        #1;
        chk("sim_busy_a_comb", 32'(busy_a), 32'd0);
        step();
        issue = 1'b0; RegWrite = 1'b0;
        #1;
        chk("sim_busy_a", 32'(busy_a), 32'd1);
        chk("sim_da", da, 32'd1);
        chk("sim_cnt", 32'(busy_cnt), 32'd2);
        // issue r8 plus clearing write to busy r2
        issue = 1'b1; issue_reg = 5'd8; RegWrite = 1'b1; rc = 5'd2; dc = 32'd2; rb = 5'd2; ra = 5'd8;
        #1;
        chk("mix_busy_b_comb", 32'(busy_b), 32'd0);
        chk("mix_db_comb", db, 32'd2);
        step();
        issue = 1'b0; RegWrite = 1'b0;
        #1;
        chk("mix_cnt", 32'(busy_cnt), 32'd2);
        chk("mix_busy_a", 32'(busy_a), 32'd1);
        chk("mix_busy_b", 32'(busy_b), 32'd0);
        // retire r4 and r8
        RegWrite = 1'b1; rc = 5'd4; dc = 32'd44;
        step();
        rc = 5'd8; dc = 32'd88;
        step();
        RegWrite = 1'b0;
        #1;
        chk("drain_cnt", 32'(busy_cnt), 32'd0);
        // saturation
        issue = 1'b1;
        for (int i = 1; i < 32; i++) begin
            issue_reg = 5'(i);
            step();
        end
        issue = 1'b0; ra = 5'd31; rb = 5'd0;
        #1;
        chk("sat_cnt", 32'(busy_cnt), 32'd31);
        chk("sat_busy_a", 32'(busy_a), 32'd1);
        chk("sat_busy_b_r0", 32'(busy_b), 32'd0);
        issue = 1'b1; issue_reg = 5'd1;
        step();
        issue = 1'b0;
        #1;
        chk("sat_reissue_cnt", 32'(busy_cnt), 32'd31);
        RegWrite = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rc = 5'(i); dc = 32'(i + 100);
            step();
        end
        RegWrite = 1'b0; ra = 5'd17; rb = 5'd31;
        #1;
        chk("unsat_cnt", 32'(busy_cnt), 32'd0);
        chk("unsat_busy_a", 32'(busy_a), 32'd0);
        chk("unsat_da", da, 32'd117);
        chk("unsat_db", db, 32'd131);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
